bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_if.sv | 13 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter returns busy/done/bcd/overflow.
interface bin2bcd_seq_if;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double dabble, one step per cycle).
// Optional macro BIN2BCD_SATURATE_EN: results above 9999 saturate bcd to 16'h9999.
//
// state | meaning
// IDLE  | waiting for start; bcd/overflow hold the last result
// SHIFT | one add-3/shift step per cycle, 16 steps
// DONE  | one-cycle done pulse; result already visible on bcd/overflow
module bin2bcd_seq (
    input  logic          clock,
    input  logic          resetn,
    bin2bcd_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [19:0] scratch_q, scratch_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_next_q, ovf_next_d;
    logic [15:0] bcd_q, bcd_d;
    logic        overflow_q, overflow_d;

    logic [19:0] adj;
    logic [35:0] step;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = scratch_q[4*i +: 4];
        end
        step = {adj, shreg_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d    = bus.bin;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_next_d = (bus.bin > 16'd9999);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = step[35:16];
                shreg_d   = step[15:0];
                cnt_d     = cnt_q + 5'd1;
                // Last step: publish the finished digits so scratch never reaches bcd mid-way
                if (cnt_q == 5'd15) begin
                    state_d    = DONE;
                    overflow_d = ovf_next_q;
`ifdef BIN2BCD_SATURATE_EN
                    bcd_d      = ovf_next_q ? 16'h9999 : step[31:16];
`else
                    bcd_d      = step[31:16];
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
endmodule
